// File: rtl/shift_sequencer.sv
// Sequencer in front of the 4-bit combinational shifter: loads an operand, steps it N times, reports done.
// Optional abort input is compiled in when SHIFT_SEQ_ABORT_EN is defined.
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             rot,
    input  logic             fill,
    input  logic [CNT_W-1:0] steps,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] sh_Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] sh_I,
    output logic             sh_D,
    output logic             sh_R,
    output logic             sh_F,
    output logic             sh_En
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_qNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_dir;
    logic             r_rot;
    logic             r_fill;
    logic             w_dirNext;
    logic             w_rotNext;
    logic             w_fillNext;
    logic             w_abort;

`ifdef SHIFT_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_cnt  <= '0;
            r_dir  <= 1'b0;
            r_rot  <= 1'b0;
            r_fill <= 1'b0;
        end else begin
            r_q    <= w_qNext;
            r_cnt  <= w_cntNext;
            r_dir  <= w_dirNext;
            r_rot  <= w_rotNext;
            r_fill <= w_fillNext;
        end
    end

    // Abort outranks the final-step transition and leaves Q at the partial value.
    always_comb begin
        w_stateNext = r_state;
        w_qNext     = r_q;
        w_cntNext   = r_cnt;
        w_dirNext   = r_dir;
        w_rotNext   = r_rot;
        w_fillNext  = r_fill;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_qNext    = load_val;
                    w_cntNext  = steps;
                    w_dirNext  = dir;
                    w_rotNext  = rot;
                    w_fillNext = fill;
                    w_stateNext = (steps == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_abort) begin
                    w_cntNext   = '0;
                    w_stateNext = ST_IDLE;
                end else begin
                    w_qNext   = sh_Y;
                    w_cntNext = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_stateNext = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    assign busy  = (r_state == ST_SHIFT);
    assign sh_En = (r_state == ST_SHIFT);
    assign done  = (r_state == ST_DONE);
    assign Q     = r_q;
    assign sh_I  = r_q;
    assign sh_D  = r_dir;
    assign sh_R  = r_rot;
    assign sh_F  = r_fill;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: shifter model on sh_Y, transaction-level reference model, directed and random phases.
module tb_shift_sequencer;

    localparam int W    = 4;
    localparam int CW   = 3;
    localparam int MASK = (1 << W) - 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  load_val;
    logic          dir;
    logic          rot;
    logic          fill;
    logic [CW-1:0] steps;
    logic          abort;
    logic [W-1:0]  sh_Y;
    logic          busy;
    logic          done;
    logic [W-1:0]  Q;
    logic [W-1:0]  sh_I;
    logic          sh_D;
    logic          sh_R;
    logic          sh_F;
    logic          sh_En;

    int nVectors;
    int nMiscompares;
    bit checkEn;

    shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load_val (load_val),
        .dir      (dir),
        .rot      (rot),
        .fill     (fill),
        .steps    (steps),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .sh_Y     (sh_Y),
        .busy     (busy),
        .done     (done),
        .Q        (Q),
        .sh_I     (sh_I),
        .sh_D     (sh_D),
        .sh_R     (sh_R),
        .sh_F     (sh_F),
        .sh_En    (sh_En)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One application of the single-bit shift/rotate rule, done arithmetically.
    function automatic int stepOnce(input int x, input logic d, input logic r, input logic f);
        int outBit;
        if (!d) begin
            outBit = r ? ((x >> (W - 1)) & 1) : int'(f);
            return ((x << 1) | outBit) & MASK;
        end
        outBit = r ? (x & 1) : int'(f);
        return ((x >> 1) | (outBit << (W - 1))) & MASK;
    endfunction

    function automatic logic [W-1:0] applyN(input logic [W-1:0] v, input int n,
                                            input logic d, input logic r, input logic f);
        int x;
        x = int'(v);
        for (int i = 0; i < n; i++) x = stepOnce(x, d, r, f);
        return W'(x);
    endfunction

    // Combinational shifter the sequencer drives.
    always_comb begin
        sh_Y = sh_I;
        if (sh_En) sh_Y = W'(stepOnce(int'(sh_I), sh_D, sh_R, sh_F));
    end

    // Reference model: an accepted operation lasts N+1 cycles (N busy, one done).
    bit         mActive;
    int         mCycle;
    int         mN;
    logic [W-1:0] mLoad;
    logic [W-1:0] mQ;
    logic       mDir;
    logic       mRot;
    logic       mFill;

    always @(posedge clk) begin
        if (rst) begin
            mActive = 1'b0;
            mCycle  = 0;
            mQ      = '0;
            mDir    = 1'b0;
            mRot    = 1'b0;
            mFill   = 1'b0;
        end else if (mActive) begin
`ifdef SHIFT_SEQ_ABORT_EN
            if (abort && mCycle <= mN) begin
                mQ      = applyN(mLoad, mCycle - 1, mDir, mRot, mFill);
                mActive = 1'b0;
            end else
`endif
            if (mCycle == mN + 1) begin
                mQ      = applyN(mLoad, mN, mDir, mRot, mFill);
                mActive = 1'b0;
            end else begin
                mCycle++;
            end
        end else if (start) begin
            mActive = 1'b1;
            mCycle  = 1;
            mN      = int'(steps);
            mLoad   = load_val;
            mDir    = dir;
            mRot    = rot;
            mFill   = fill;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        logic         eBusy;
        logic         eDone;
        logic [W-1:0] eQ;
        if (checkEn) begin
            if (mActive) begin
                eBusy = (mCycle <= mN);
                eDone = (mCycle == mN + 1);
                eQ    = applyN(mLoad, mCycle - 1, mDir, mRot, mFill);
            end else begin
                eBusy = 1'b0;
                eDone = 1'b0;
                eQ    = mQ;
            end
            checkOutput("busy", 32'(busy), 32'(eBusy));
            checkOutput("done", 32'(done), 32'(eDone));
            checkOutput("sh_En", 32'(sh_En), 32'(eBusy));
            checkOutput("Q", 32'(Q), 32'(eQ));
            checkOutput("sh_I", 32'(sh_I), 32'(eQ));
            checkOutput("sh_D", 32'(sh_D), 32'(mDir));
            checkOutput("sh_R", 32'(sh_R), 32'(mRot));
            checkOutput("sh_F", 32'(sh_F), 32'(mFill));
        end
    end

    // Presents one start request; returns two time units into cycle 1 of the operation.
    task automatic applyStimulus(input logic [W-1:0] v, input logic d, input logic r,
                                 input logic f, input logic [CW-1:0] n);
        @(posedge clk); #2;
        start    = 1'b1;
        load_val = v;
        dir      = d;
        rot      = r;
        fill     = f;
        steps    = n;
        @(posedge clk); #2;
        start    = 1'b0;
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        checkEn      = 1'b0;
        rst          = 1'b1;
        start        = 1'b0;
        load_val     = '0;
        dir          = 1'b0;
        rot          = 1'b0;
        fill         = 1'b0;
        steps        = '0;
        abort        = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkEn = 1'b1;
        rst     = 1'b0;
        @(negedge clk);
        checkOutput("reset Q", 32'(Q), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);

        $display("[TB] directed: left shift 1011 by 2");
        applyStimulus(4'b1011, 1'b0, 1'b0, 1'b0, 3'd2);
        @(negedge clk);
        checkOutput("lsh c1 busy", 32'(busy), 32'h1);
        @(negedge clk);
        checkOutput("lsh c2 Q", 32'(Q), 32'b0110);
        @(negedge clk);
        checkOutput("lsh c3 done", 32'(done), 32'h1);
        checkOutput("lsh c3 Q", 32'(Q), 32'b1100);

        $display("[TB] directed: right rotate 1011 by 1, left rotate 0001 by 4");
        applyStimulus(4'b1011, 1'b1, 1'b1, 1'b0, 3'd1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rrot done", 32'(done), 32'h1);
        checkOutput("rrot Q", 32'(Q), 32'b1101);
        applyStimulus(4'b0001, 1'b0, 1'b1, 1'b0, 3'd4);
        repeat (5) @(negedge clk);
        checkOutput("lrot done", 32'(done), 32'h1);
        checkOutput("lrot Q", 32'(Q), 32'b0001);

        $display("[TB] directed: zero steps");
        applyStimulus(4'b0110, 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        checkOutput("zero done", 32'(done), 32'h1);
        checkOutput("zero sh_En", 32'(sh_En), 32'h0);
        checkOutput("zero Q", 32'(Q), 32'b0110);

        $display("[TB] directed: start while busy");
        applyStimulus(4'b1011, 1'b0, 1'b1, 1'b0, 3'd5);
        @(posedge clk); #2;
        start    = 1'b1;
        load_val = 4'b1111;
        dir      = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("busy-start done", 32'(done), 32'h1);
        checkOutput("busy-start Q", 32'(Q), 32'b0111);
        checkOutput("busy-start sh_D", 32'(sh_D), 32'h0);

        $display("[TB] directed: reset mid-operation");
        applyStimulus(4'b1011, 1'b0, 1'b0, 1'b1, 3'd6);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst-mid Q", 32'(Q), 32'h0);
        checkOutput("rst-mid busy", 32'(busy), 32'h0);
        checkOutput("rst-mid done", 32'(done), 32'h0);
        applyStimulus(4'b0011, 1'b1, 1'b0, 1'b1, 3'd2);
        repeat (3) @(negedge clk);
        checkOutput("post-rst Q", 32'(Q), 32'b1100);

`ifdef SHIFT_SEQ_ABORT_EN
        $display("[TB] directed: abort");
        applyStimulus(4'b1000, 1'b1, 1'b0, 1'b1, 3'd3);
        @(posedge clk); #2;
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        @(negedge clk);
        checkOutput("abort Q", 32'(Q), 32'b1100);
        checkOutput("abort busy", 32'(busy), 32'h0);
        checkOutput("abort done", 32'(done), 32'h0);
`endif

        $display("[TB] random phase");
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            rst      = ($urandom_range(0, 79) == 0);
            start    = ($urandom_range(0, 3) == 0);
            load_val = W'($urandom);
            dir      = 1'($urandom);
            rot      = 1'($urandom);
            fill     = 1'($urandom);
            steps    = CW'($urandom);
`ifdef SHIFT_SEQ_ABORT_EN
            abort    = ($urandom_range(0, 9) == 0);
`endif
        end
        @(posedge clk); #2;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Sequential control stage that sits directly upstream of the 4-bit combinational shifter (I, D, R, F, En → Y).
- Loads an operand, drives the shifter's control inputs for a commanded number of single-bit steps, and registers the shifter output back each cycle.
- Provides a start/busy/done handshake so a controller can request multi-bit shifts and rotates.

Parameters:
- WIDTH, 4, datapath width; must match the shifter's I/Y width.
- CNT_W, 3, width of the step count; maximum steps = 2^CNT_W - 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- load_val  input  WIDTH  operand captured on an accepted start.
- dir  input  1  0 = left (toward MSB), 1 = right; captured on start.
- rot  input  1  0 = shift with fill, 1 = rotate; captured on start.
- fill  input  1  fill bit for non-rotate shifts; captured on start.
- steps  input  CNT_W  number of single-bit steps; captured on start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when the result is valid.
- Q  output  WIDTH  registered result / working value.
- sh_I  output  WIDTH  to shifter I; always equals Q.
- sh_D  output  1  to shifter D; captured dir.
- sh_R  output  1  to shifter R; captured rot.
- sh_F  output  1  to shifter F; captured fill.
- sh_En  output  1  to shifter En; high only in SHIFT.
- sh_Y  input  WIDTH  from shifter Y.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. On rst:
  - state = IDLE;
  - Q, cnt, captured dir/rot/fill = 0;
  - busy = 0, done = 0, sh_En = 0.
  - rst overrides every other input, including mid-SHIFT: the partial result is discarded and no done is issued.
- Shifter contract (bench model must implement exactly this):
  - En = 0: Y = I.
  - Left: shift gives Y = {I[W-2:0], F}; rotate gives Y = {I[W-2:0], I[W-1]}.
  - Right: shift gives Y = {F, I[W-1:1]}; rotate gives Y = {I[0], I[W-1:1]}.
- IDLE:
  - busy = 0, done = 0.
  - If start = 1: Q <= load_val, cnt <= steps, dir/rot/fill are captured, and the next state is DONE if steps == 0, else SHIFT.
- SHIFT:
  - busy = 1 and sh_En = 1.
  - Each edge: Q <= sh_Y and cnt <= cnt - 1.
  - When cnt == 1 at the edge, go to DONE; otherwise stay in SHIFT.
  - Exactly `steps` shifter evaluations occur.
- DONE:
  - done = 1 for exactly one cycle, busy = 0, and Q holds the final result.
  - Unconditionally returns to IDLE.
  - start is ignored in this cycle.
- Latency: with start accepted at edge 0, SHIFT occupies cycles 1..N and done is high in cycle N+1. For N = 0, done is high in cycle 1 with Q = load_val.
- start while busy or during DONE is ignored; captured parameters do not change.
- Q holds its value in IDLE indefinitely until the next accepted start.
- cnt never underflows; it is only decremented in SHIFT, where cnt ≥ 1.
- Outputs busy, done and sh_En decode directly from registered state (no combinational path from start).

Optional Feature:
- Macro: SHIFT_SEQ_ABORT_EN.
- Defined:
  - Adds input port `abort` (1 bit).
  - abort = 1 in SHIFT moves the state to IDLE at that edge.
  - That edge performs no Q update, so Q holds the partial value; cnt is cleared and no done pulse is issued.
  - abort is ignored in IDLE and DONE.
  - abort takes priority over the cnt == 1 → DONE transition.
- Not defined: the port is absent and SHIFT always runs to completion.

Test Plan:
- Left shift: load_val = 1011, dir = 0, rot = 0, fill = 0, steps = 2 → busy high 2 cycles, then done pulse with Q = 1100; intermediate Q after first step = 0110.
- Right rotate: load_val = 1011, dir = 1, rot = 1, steps = 1 → done in cycle 2 with Q = 1101. Follow with left rotate of 0001, steps = 4 → Q = 0001.
- Zero steps: load_val = 0110, steps = 0 → no busy, done in cycle 1 with Q = 0110, sh_En never asserted.
- Start while busy: start with steps = 5, then pulse start again with load_val = 1111 in cycle 2 → ignored; result reflects the original operand, and exactly one done pulse occurs.
- Reset mid-operation: steps = 6, assert rst in cycle 3 → next cycle Q = 0000, busy = 0, no done; a subsequent start operates normally.
- With SHIFT_SEQ_ABORT_EN: load_val = 1000, right shift, fill = 1, steps = 3, abort in cycle 2 → Q = 1100 (one step applied), IDLE, no done.
